mon_wr_arb: RTL and testbench

Write-port arbiter for the monitor trace RAM. Takes up to four independent monitor write requesters (host-bus command monitor, display-fetch monitor, etc.), each using a wrreq/wrack handshake with its own address and data. It grants them round-robin onto the single RAM write port, one write per grant. It also applies a global capture enable and keeps saturating write and drop statistics for the monitor readout path.

---
 rtl/mon_pkg.sv | 22 ++
 rtl/mon_wr_arb_if.sv | 42 ++++
 rtl/mon_rr_pick.sv | 36 +++
 rtl/mon_wr_arb.sv | 146 ++++++++++++++
 tb/tb_mon_wr_arb.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mon_pkg.sv
// Shared definitions for the monitor trace RAM write arbiter.
//   - FSM state encodings (IDLE / WRITE / ACK)
//   - default trace RAM geometry and statistics counter width
//   - saturating increment helper for the statistics counters
package mon_pkg;

    localparam logic [1:0] MON_IDLE  = 2'b00;
    localparam logic [1:0] MON_WRITE = 2'b01;
    localparam logic [1:0] MON_ACK   = 2'b10;

    localparam int MON_AW = 11;
    localparam int MON_DW = 18;
    localparam int MON_CW = 16;

    localparam logic [MON_CW-1:0] MON_CNT_MAX = '1;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [MON_CW-1:0] sat_inc(input logic [MON_CW-1:0] v);
        return (v == MON_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mon_wr_arb_if.sv
// Bus bundle between the monitor write requesters, the arbiter and the
// trace RAM write port.
//   req_wrreq  per-requester write request (level)
//   req_wrack  per-requester acknowledge (one-cycle, one-hot)
//   req_waddr  packed addresses, requester i at [i*AW +: AW]
//   req_wdata  packed data,      requester i at [i*DW +: DW]
//   mem_we / mem_addr / mem_wdata  trace RAM write port
//
// Handshake: a requester raises req_wrreq with stable address/data and holds
// all three until it sees req_wrack high; the transfer completes on the clock
// edge where req_wrreq & req_wrack are both 1, and the requester drops (or
// re-arms) its request after that edge. Withdrawing a request before it is
// granted is allowed and the request is simply never served.
//
// master: the requester side.  slave: the arbiter.
interface mon_wr_arb_if
    import mon_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = MON_AW,
    parameter int DW   = MON_DW
);

    logic [NREQ-1:0]    req_wrreq;
    logic [NREQ-1:0]    req_wrack;
    logic [NREQ*AW-1:0] req_waddr;
    logic [NREQ*DW-1:0] req_wdata;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;

    modport master (
        output req_wrreq, req_waddr, req_wdata,
        input  req_wrack, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_wrreq, req_waddr, req_wdata,
        output req_wrack, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mon_rr_pick.sv
// Combinational round-robin picker.
//   req   request vector, one bit per requester
//   last  index of the most recently granted requester
//   valid at least one request is pending
//   idx   winner: first requesting index searching last+1, last+2, ... mod NREQ
module mon_rr_pick
    import mon_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic            valid,
    output logic [1:0]      idx
);

    // Two ordered passes realise the wrap: first the indices above last,
    // then the indices from 0 up to and including last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && (i > int'(last)) && req[i]) begin
                valid = 1'b1;
                idx   = 2'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && (i <= int'(last)) && req[i]) begin
                valid = 1'b1;
                idx   = 2'(i);
            end
        end
    end

endmodule

// File: rtl/mon_wr_arb.sv
// Round-robin write-port arbiter for the monitor trace RAM.
// Up to four requesters share one RAM write port, one write per grant,
// with a global capture enable and saturating write/drop statistics.
//   clk, rst   single clock, synchronous active-high reset
//   bus        requester handshakes and RAM write port (slave side)
//   mon_en     capture enable, sampled at grant; 0 = acknowledge and drop
//   cnt_clr    clears wr_cnt / drop_cnt, wins over a coincident increment
//   grant_id   index of the last granted requester
//   busy       high whenever the FSM is not idle
//   wr_cnt     writes performed (saturating)
//   drop_cnt   writes dropped while capture was disabled (saturating)
//   state_dbg  raw FSM state for observation
module mon_wr_arb
    import mon_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = MON_AW,
    parameter int DW   = MON_DW
) (
    input  logic              clk,
    input  logic              rst,
    mon_wr_arb_if.slave       bus,
    input  logic              mon_en,
    input  logic              cnt_clr,
    output logic [1:0]        grant_id,
    output logic              busy,
    output logic [MON_CW-1:0] wr_cnt,
    output logic [MON_CW-1:0] drop_cnt,
    output logic [1:0]        state_dbg
);

    logic [1:0]        state_q, state_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        grant_q, grant_d;
    logic              cap_q, cap_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic [MON_CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [MON_CW-1:0] drop_cnt_q, drop_cnt_d;

    logic              pick_valid;
    logic [1:0]        pick_idx;
    logic              wr_inc;
    logic              drop_inc;

    mon_rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.req_wrreq),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        cap_d   = cap_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_inc   = 1'b0;
        drop_inc = 1'b0;

        case (state_q)
            MON_IDLE: begin
                // Requests are only looked at here, so anything arriving
                // during WRITE/ACK simply waits for the next idle cycle.
                if (pick_valid) begin
                    state_d = MON_WRITE;
                    last_d  = pick_idx;
                    grant_d = pick_idx;
                    cap_d   = mon_en;
                    for (int i = 0; i < NREQ; i++) begin
                        if (pick_idx == 2'(i)) begin
                            addr_d = bus.req_waddr[i*AW +: AW];
                            data_d = bus.req_wdata[i*DW +: DW];
                        end
                    end
                end
            end
            MON_WRITE: begin
                wr_inc   = cap_q;
                drop_inc = !cap_q;
                state_d  = MON_ACK;
            end
            MON_ACK: begin
                state_d = MON_IDLE;
            end
            default: begin
                state_d = MON_IDLE;
            end
        endcase

        if (cnt_clr) begin
            wr_cnt_d   = '0;
            drop_cnt_d = '0;
        end else begin
            wr_cnt_d   = wr_inc   ? sat_inc(wr_cnt_q)   : wr_cnt_q;
            drop_cnt_d = drop_inc ? sat_inc(drop_cnt_q) : drop_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MON_IDLE;
            last_q     <= 2'(NREQ - 1);
            grant_q    <= '0;
            cap_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            cap_q      <= cap_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_cnt_q   <= wr_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Write strobe and acknowledge are pure decodes of registered state, so
    // mon_en changing mid-transfer cannot disturb the write in flight and a
    // reset taken in WRITE leaves no acknowledge behind.
    always_comb begin
        bus.req_wrack = '0;
        if (state_q == MON_ACK) begin
            for (int i = 0; i < NREQ; i++) begin
                bus.req_wrack[i] = (grant_q == 2'(i));
            end
        end
    end

    assign bus.mem_we    = (state_q == MON_WRITE) && cap_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = data_q;

    assign grant_id  = grant_q;
    assign busy      = (state_q != MON_IDLE);
    assign wr_cnt    = wr_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mon_wr_arb.sv
// Testbench for mon_wr_arb with three requesters.
module tb_mon_wr_arb;
  import mon_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 11;
  localparam int DW   = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        mon_en  = 1'b1;
  logic        cnt_clr = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] wr_cnt;
  logic [15:0] drop_cnt;
  logic [1:0]  state_dbg;

  mon_wr_arb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  mon_wr_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mon_en    (mon_en),
    .cnt_clr   (cnt_clr),
    .grant_id  (grant_id),
    .busy      (busy),
    .wr_cnt    (wr_cnt),
    .drop_cnt  (drop_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- requester state ----------------
  logic [NREQ-1:0]         r_req    = '0;
  logic [NREQ-1:0][AW-1:0] r_addr   = '0;
  logic [NREQ-1:0][DW-1:0] r_data   = '0;
  logic [NREQ-1:0]         clr_pend = '0;
  bit                      rand_mode = 1'b0;
  int                      cyc = 0;

  // ---------------- behavioural model ----------------
  // m_age: -1 when no transfer is in progress, otherwise the number of
  // cycles since the grant edge (1 = write cycle, 2 = acknowledge cycle).
  int                   m_age = -1;
  int                   m_g   = 0;
  logic [1:0]           m_last = 2'(NREQ - 1);
  logic [1:0]           m_gid = '0;
  logic [AW-1:0]        m_addr = '0;
  logic [DW-1:0]        m_data = '0;
  logic [15:0]          m_wr = '0;
  logic [15:0]          m_drop = '0;
  bit                   m_cap = 1'b0;
  logic [AW+DW-1:0]     exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive();
    bus.req_wrreq = r_req;
    bus.req_waddr = r_addr;
    bus.req_wdata = r_data;
  endtask

  task automatic model_step();
    bit inc_w;
    bit inc_d;
    if (rst) begin
      m_age = -1; m_g = 0; m_last = 2'(NREQ - 1); m_gid = '0;
      m_addr = '0; m_data = '0; m_wr = '0; m_drop = '0; m_cap = 1'b0;
      exp_q.delete();
      return;
    end
    inc_w = (m_age == 1) && m_cap;
    inc_d = (m_age == 1) && !m_cap;
    if (cnt_clr) m_wr = '0;
    else if (inc_w && m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
    if (cnt_clr) m_drop = '0;
    else if (inc_d && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;

    if (m_age == 1) m_age = 2;
    else if (m_age == 2) m_age = -1;
    else begin
      for (int k = 1; k <= NREQ; k++) begin
        int i = (int'(m_last) + k) % NREQ;
        if (m_age < 0 && r_req[i]) begin
          m_age  = 1;
          m_g    = i;
          m_last = 2'(i);
          m_gid  = 2'(i);
          m_addr = r_addr[i];
          m_data = r_data[i];
          m_cap  = mon_en;
          if (mon_en) exp_q.push_back({r_addr[i], r_data[i]});
        end
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  task automatic compare();
    logic [NREQ-1:0]  exp_ack;
    logic [AW+DW-1:0] e;
    exp_ack = (m_age == 2) ? NREQ'(1 << m_g) : '0;
    check("mem_we",    32'(bus.mem_we),    32'(m_age == 1 && m_cap));
    check("req_wrack", 32'(bus.req_wrack), 32'(exp_ack));
    check("busy",      32'(busy),          32'(m_age > 0));
    check("grant_id",  32'(grant_id),      32'(m_gid));
    check("mem_addr",  32'(bus.mem_addr),  32'(m_addr));
    check("mem_wdata", 32'(bus.mem_wdata), 32'(m_data));
    check("wr_cnt",    32'(wr_cnt),        32'(m_wr));
    check("drop_cnt",  32'(drop_cnt),      32'(m_drop));
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) check("sb_unexpected_write", 32'(1), 32'(0));
      else begin
        e = exp_q.pop_front();
        check("sb_write", 32'({bus.mem_addr, bus.mem_wdata}), 32'(e));
      end
    end
    clr_pend = bus.req_wrack & r_req;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (!r_req[i] && $urandom_range(0, 2) == 0) begin
        r_req[i]  = 1'b1;
        r_addr[i] = AW'($urandom);
        r_data[i] = DW'($urandom);
      end
    end
    mon_en  = ($urandom_range(0, 3) != 0);
    cnt_clr = ($urandom_range(0, 39) == 0);
    rst     = ($urandom_range(0, 149) == 0);
  endtask

  // One clock: model follows the edge, requesters react after it, outputs
  // are compared at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    r_req = r_req & ~clr_pend;
    clr_pend = '0;
    if (rand_mode) rand_inputs();
    drive();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1; r_req = '0; clr_pend = '0; cnt_clr = 1'b0; mon_en = 1'b1;
    drive();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic do_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r_req[i] = 1'b1; r_addr[i] = a; r_data[i] = d;
    drive();
    cycle(); cycle(); cycle();
  endtask

  // ---------------- stimulus ----------------
  int exp_order[4] = '{0, 1, 2, 0};
  int g_seq[$];
  int g_cyc[$];
  logic [AW-1:0] a_seq[$];
  int ack1_seen;

  initial begin
    drive();
    do_reset();

    // Reset values
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_busy",     32'(busy), 32'h0);
    check("rst_mem_we",   32'(bus.mem_we), 32'h0);
    check("rst_wrack",    32'(bus.req_wrack), 32'h0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_wdata",    32'(bus.mem_wdata), 32'h0);
    check("rst_wr_cnt",   32'(wr_cnt), 32'h0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'h0);

    // Single requester
    r_req[0] = 1'b1; r_addr[0] = 11'h005; r_data[0] = 18'h1_0040; mon_en = 1'b1;
    drive();
    cycle();
    check("t1_we",    32'(bus.mem_we), 32'h1);
    check("t1_addr",  32'(bus.mem_addr), 32'h005);
    check("t1_data",  32'(bus.mem_wdata), 32'h1_0040);
    cycle();
    check("t1_ack",   32'(bus.req_wrack), 32'b001);
    check("t1_wrcnt", 32'(wr_cnt), 32'h1);
    cycle();
    check("t1_idle",  32'(busy), 32'h0);

    // Contention, all requesters held high from reset
    rst = 1'b1; r_req = '0; clr_pend = '0; drive(); cycle();
    for (int i = 0; i < NREQ; i++) begin
      r_req[i] = 1'b1; r_addr[i] = AW'(11'h100 + i); r_data[i] = DW'(i + 7);
    end
    drive(); cycle();
    rst = 1'b0;
    for (int t = 0; t < 30 && g_seq.size() < 4; t++) begin
      cycle();
      if (bus.mem_we === 1'b1) a_seq.push_back(bus.mem_addr);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_wrack[i] === 1'b1) begin
          g_seq.push_back(i);
          g_cyc.push_back(cyc);
        end
      end
      r_req = '1; drive();
    end
    check("t2_nacks", 32'(g_seq.size()), 32'd4);
    for (int j = 0; j < g_seq.size() && j < 4; j++) begin
      check("t2_order", 32'(g_seq[j]), 32'(exp_order[j]));
      check("t2_addr",  32'(a_seq[j]), 32'(11'h100 + exp_order[j]));
      if (j > 0) check("t2_spacing", 32'(g_cyc[j] - g_cyc[j-1]), 32'd3);
    end

    // Capture disabled, toggled in WRITE
    do_reset();
    mon_en = 1'b0; r_req[1] = 1'b1; r_addr[1] = 11'h007; r_data[1] = 18'h3;
    drive();
    cycle();
    check("t3_no_we", 32'(bus.mem_we), 32'h0);
    check("t3_busy",  32'(busy), 32'h1);
    mon_en = 1'b1;
    cycle();
    check("t3_ack",   32'(bus.req_wrack), 32'b010);
    check("t3_drop",  32'(drop_cnt), 32'h1);
    check("t3_wr",    32'(wr_cnt), 32'h0);
    cycle();

    // Saturation and clear
    do_reset();
    force dut.wr_cnt_q = 16'hFFFD;
    m_wr = 16'hFFFD;
    cycle();
    release dut.wr_cnt_q;
    do_write(2, 11'h010, 18'h00AA);
    check("t4_fffe", 32'(wr_cnt), 32'hFFFE);
    do_write(0, 11'h011, 18'h00BB);
    check("t4_ffff", 32'(wr_cnt), 32'hFFFF);
    do_write(1, 11'h012, 18'h00CC);
    check("t4_sat",  32'(wr_cnt), 32'hFFFF);
    r_req[2] = 1'b1; drive();
    cycle();
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    check("t4_clr",  32'(wr_cnt), 32'h0);
    cycle();

    // Reset during WRITE
    do_reset();
    r_req[2] = 1'b1; r_addr[2] = 11'h2AA; r_data[2] = 18'h1_5555; drive();
    cycle();
    check("t5_we",    32'(bus.mem_we), 32'h1);
    rst = 1'b1;
    cycle();
    check("t5_noack", 32'(bus.req_wrack), 32'h0);
    check("t5_we0",   32'(bus.mem_we), 32'h0);
    check("t5_busy",  32'(busy), 32'h0);
    check("t5_addr",  32'(bus.mem_addr), 32'h0);
    check("t5_held",  32'(r_req[2]), 32'h1);
    rst = 1'b0;
    cycle();
    check("t5_rewe",  32'(bus.mem_addr), 32'h2AA);
    cycle();
    check("t5_reack", 32'(bus.req_wrack), 32'b100);
    cycle();

    // Withdrawn request
    do_reset();
    ack1_seen = 0;
    r_req[0] = 1'b1; r_addr[0] = 11'h020; drive();
    cycle();
    r_req[1] = 1'b1; r_addr[1] = 11'h021; drive();
    cycle();
    if (bus.req_wrack[1] === 1'b1) ack1_seen++;
    r_req[1] = 1'b0; drive();
    for (int t = 0; t < 4; t++) begin
      cycle();
      if (bus.req_wrack[1] === 1'b1) ack1_seen++;
    end
    check("t6_no_ack1", 32'(ack1_seen), 32'h0);
    check("t6_idle",    32'(busy), 32'h0);

    // Randomized traffic
    rand_mode = 1'b1;
    for (int t = 0; t < 3000; t++) cycle();
    rand_mode = 1'b0;
    rst = 1'b0; cnt_clr = 1'b0;
    for (int t = 0; t < 20; t++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
